// File: rtl/bsg_two_fifo_rv_pkg.sv
//------------------------------------------------------------------------------
// Module   : bsg_two_fifo_rv_pkg
// Purpose  : Shared depth/pointer definitions for the two-entry ready/valid FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bsg_two_fifo_rv_pkg;

    localparam int unsigned depth_lp     = 2;
    localparam int unsigned ptr_width_lp = 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

endpackage

`default_nettype wire

// File: rtl/bsg_two_fifo_rv_if.sv
//------------------------------------------------------------------------------
// Module   : bsg_two_fifo_rv_if
// Purpose  : Enqueue/dequeue handshake bundle; signal names follow the FIFO view.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bsg_two_fifo_rv_if #(
    parameter int width_p = 8
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o
    );

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o
    );
endinterface

`default_nettype wire

// File: rtl/bsg_dff_en.sv
//------------------------------------------------------------------------------
// Module   : bsg_dff_en
// Purpose  : Enable-gated register without reset; harden_p picks the macro flavour.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_dff_en #(
    parameter int width_p  = 8,
    parameter int harden_p = 0
) (
    input  wire logic               clk_i,
    input  wire logic               en_i,
    input  wire logic [width_p-1:0] data_i,
    output logic      [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    generate
        if (harden_p != 0) begin : g_hard
            // Stand-in for the hardened cell; identical behaviour in RTL.
            always_ff @(posedge clk_i) begin
                if (en_i) data_q <= data_i;
            end
        end else begin : g_soft
            always_ff @(posedge clk_i) begin
                if (en_i) data_q <= data_i;
            end
        end
    endgenerate

    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/bsg_two_fifo_rv_mem.sv
//------------------------------------------------------------------------------
// Module   : bsg_two_fifo_rv_mem
// Purpose  : Two-slot storage of enable registers with a read mux; not reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_two_fifo_rv_mem
    import bsg_two_fifo_rv_pkg::*;
#(
    parameter int width_p  = 8,
    parameter int harden_p = 0
) (
    input  wire logic               clk_i,
    input  wire logic               w_v_i,
    input  wire ptr_t               w_addr_i,
    input  wire logic [width_p-1:0] w_data_i,
    input  wire ptr_t               r_addr_i,
    output logic      [width_p-1:0] r_data_o
);

    logic [width_p-1:0] slot_data [depth_lp];

    generate
        for (genvar i = 0; i < depth_lp; i++) begin : g_slot
            logic w_en;
            assign w_en = w_v_i & (w_addr_i == ptr_t'(i));

            bsg_dff_en #(
                .width_p  (width_p),
                .harden_p (harden_p)
            ) u_reg (
                .clk_i  (clk_i),
                .en_i   (w_en),
                .data_i (w_data_i),
                .data_o (slot_data[i])
            );
        end
    endgenerate

    assign r_data_o = slot_data[r_addr_i];

endmodule

`default_nettype wire

// File: rtl/bsg_two_fifo_rv.sv
//------------------------------------------------------------------------------
// Module   : bsg_two_fifo_rv
// Purpose  : Two-entry ready/valid FIFO; pointers and full/empty flags live here.
//            Optional macro BSG_TWO_FIFO_RV_BYPASS_EN adds an empty-state bypass.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_two_fifo_rv
    import bsg_two_fifo_rv_pkg::*;
#(
    parameter int width_p  = 8,
    parameter int harden_p = 0
) (
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    bsg_two_fifo_rv_if.slave        io
);

    ptr_t               wptr_q, wptr_d;
    ptr_t               rptr_q, rptr_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               w_enq;
    logic               w_wr;
    logic               w_rd;
    logic [width_p-1:0] w_mem_data;

    assign w_enq = io.v_i & ~full_q;

`ifdef BSG_TWO_FIFO_RV_BYPASS_EN
    logic w_bypass;
    // An item consumed in the same cycle it arrives at an empty FIFO never lands in storage.
    assign w_bypass   = empty_q & io.yumi_i;
    assign w_wr       = w_enq & ~w_bypass;
    assign w_rd       = io.yumi_i & ~w_bypass;
    assign io.v_o     = ~empty_q | io.v_i;
    assign io.data_o  = empty_q ? io.data_i : w_mem_data;
`else
    assign w_wr       = w_enq;
    assign w_rd       = io.yumi_i;
    assign io.v_o     = ~empty_q;
    assign io.data_o  = w_mem_data;
`endif

    assign io.ready_o = ~full_q;

    bsg_two_fifo_rv_mem #(
        .width_p  (width_p),
        .harden_p (harden_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_wr),
        .w_addr_i (wptr_q),
        .w_data_i (io.data_i),
        .r_addr_i (rptr_q),
        .r_data_o (w_mem_data)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        if (w_wr) wptr_d = ~wptr_q;
        if (w_rd) rptr_d = ~rptr_q;
        // Simultaneous enq and deq keeps occupancy, so flags hold.
        if (w_wr && !w_rd) begin
            empty_d = 1'b0;
            if (~wptr_q == rptr_q) full_d = 1'b1;
        end else if (w_rd && !w_wr) begin
            full_d = 1'b0;
            if (~rptr_q == wptr_q) empty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        io.yumi_i |-> io.v_o);

endmodule

`default_nettype wire
